// File: rtl/stepper_position_ctrl.sv
// Position controller for a stepper phase driver: accepts absolute-target or
// homing commands, drives the direction command, counts step periods into a
// position register, and enforces limit switches, soft stop and a settle time.
module stepper_position_ctrl #(
  parameter int unsigned STEP_TIME   = 250000,
  parameter int unsigned SETTLE_TIME = 50000,
  parameter int unsigned POS_W       = 16,
  parameter int unsigned HOME_MAX    = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_home,
  input  logic [POS_W-1:0] cmd_target,
  input  logic             stop,
  input  logic             lim_up,
  input  logic             lim_down,
  output logic [1:0]       dir,
  output logic [POS_W-1:0] position,
  output logic             busy,
  output logic             done,
  output logic             fault
);

  // One shared counter serves both the step period and the settle interval.
  localparam int unsigned CNT_MAX = (STEP_TIME > SETTLE_TIME) ? STEP_TIME : SETTLE_TIME;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned HOME_W  = $clog2(HOME_MAX + 1);

  localparam logic [CNT_W-1:0]  STEP_LAST   = CNT_W'(STEP_TIME - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_TIME - 1);
  localparam logic [HOME_W-1:0] HOME_LAST   = HOME_W'(HOME_MAX - 1);

  localparam logic [1:0] DIR_UP   = 2'd0;
  localparam logic [1:0] DIR_DOWN = 2'd1;
  localparam logic [1:0] DIR_STOP = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UP,
    S_DOWN,
    S_HOME,
    S_SETTLE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [HOME_W-1:0]  home_cnt_q, home_cnt_d;
  logic [POS_W-1:0]   target_q, target_d;
  logic [POS_W-1:0]   position_q, position_d;
  logic [1:0]         dir_q, dir_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               fault_q, fault_d;
  logic               cmd_ready_q, cmd_ready_d;

  logic               step_last;
  logic [POS_W-1:0]   pos_inc;
  logic [POS_W-1:0]   pos_dec;

  assign step_last = (cnt_q == STEP_LAST);
  assign pos_inc   = position_q + POS_W'(1);
  assign pos_dec   = position_q - POS_W'(1);

  // State and registered outputs; reset forces a safe stopped, idle state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      home_cnt_q  <= '0;
      target_q    <= '0;
      position_q  <= '0;
      dir_q       <= DIR_STOP;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      home_cnt_q  <= home_cnt_d;
      target_q    <= target_d;
      position_q  <= position_d;
      dir_q       <= dir_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  // Next-state logic; within a moving state: limit fault > stop > terminal count.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    home_cnt_d = home_cnt_q;
    target_d   = target_q;
    position_d = position_q;
    fault_d    = fault_q;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          fault_d    = 1'b0;
          target_d   = cmd_target;
          cnt_d      = '0;
          home_cnt_d = '0;
          if (cmd_home) begin
            state_d = S_HOME;
          end else if (cmd_target > position_q) begin
            state_d = S_UP;
          end else if (cmd_target < position_q) begin
            state_d = S_DOWN;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      S_UP: begin
        if (lim_up) begin
          fault_d = 1'b1;
          state_d = S_SETTLE;
          cnt_d   = '0;
        end else if (stop) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end else if (step_last) begin
          position_d = pos_inc;
          cnt_d      = '0;
          if (pos_inc == target_q) begin
            state_d = S_SETTLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DOWN: begin
        if (lim_down) begin
          fault_d = 1'b1;
          state_d = S_SETTLE;
          cnt_d   = '0;
        end else if (stop) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end else if (step_last) begin
          position_d = pos_dec;
          cnt_d      = '0;
          if (pos_dec == target_q) begin
            state_d = S_SETTLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_HOME: begin
        if (lim_up) begin
          fault_d = 1'b1;
          state_d = S_SETTLE;
          cnt_d   = '0;
        end else if (lim_down) begin
          position_d = '0;
          state_d    = S_SETTLE;
          cnt_d      = '0;
        end else if (stop) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end else if (step_last) begin
          cnt_d = '0;
          if (home_cnt_q == HOME_LAST) begin
            fault_d = 1'b1;
            state_d = S_SETTLE;
          end else begin
            home_cnt_d = home_cnt_q + HOME_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state so dir/busy/ready align with the state register.
  always_comb begin
    dir_d       = DIR_STOP;
    busy_d      = (state_d != S_IDLE);
    cmd_ready_d = (state_d == S_IDLE) && !stop;
    unique case (state_d)
      S_UP:            dir_d = DIR_UP;
      S_DOWN, S_HOME:  dir_d = DIR_DOWN;
      default:         dir_d = DIR_STOP;
    endcase
  end

  assign cmd_ready = cmd_ready_q;
  assign dir       = dir_q;
  assign position  = position_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_stepper_position_ctrl.sv
// Directed bench for stepper_position_ctrl with small timing parameters.
module tb_stepper_position_ctrl;

  localparam int unsigned POS_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_home;
  logic [POS_W-1:0] cmd_target;
  logic             stop;
  logic             lim_up;
  logic             lim_down;
  logic [1:0]       dir;
  logic [POS_W-1:0] position;
  logic             busy;
  logic             done;
  logic             fault;

  int checks = 0;
  int errors = 0;

  stepper_position_ctrl #(
    .STEP_TIME   (4),
    .SETTLE_TIME (3),
    .POS_W       (POS_W),
    .HOME_MAX    (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_home   (cmd_home),
    .cmd_target (cmd_target),
    .stop       (stop),
    .lim_up     (lim_up),
    .lim_down   (lim_down),
    .dir        (dir),
    .position   (position),
    .busy       (busy),
    .done       (done),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             home;
    logic [POS_W-1:0] target;
    int               lim_at;     // cycle after accept at which lim_down rises, -1 for never
    logic [1:0]       exp_dir;    // dir one cycle after accept
    int               exp_lat;    // edges after the accept edge until done is seen
    logic [POS_W-1:0] exp_pos;
    logic             exp_fault;
    logic [POS_W-1:0] held_pos;   // position expected while homing, before lim_down
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int bound, input string name);
    int n;
    n = 0;
    while (!done && n < bound) begin
      tick();
      n++;
    end
    check(name, 32'(done), 32'd1);
  endtask

  initial begin
    int k;

    // Sequential moves: 0->3, 3->1, 1->1, 1->5, home with lim_down, home timeout, 0->2
    vecs[0] = '{1'b0, 8'd3, -1, 2'd0, 15, 8'd3, 1'b0, 8'd0};
    vecs[1] = '{1'b0, 8'd1, -1, 2'd1, 11, 8'd1, 1'b0, 8'd0};
    vecs[2] = '{1'b0, 8'd1, -1, 2'd2,  0, 8'd1, 1'b0, 8'd0};
    vecs[3] = '{1'b0, 8'd5, -1, 2'd0, 19, 8'd5, 1'b0, 8'd0};
    vecs[4] = '{1'b1, 8'd0,  7, 2'd1, 11, 8'd0, 1'b0, 8'd5};
    vecs[5] = '{1'b1, 8'd0, -1, 2'd1, 43, 8'd0, 1'b1, 8'd0};
    vecs[6] = '{1'b0, 8'd2, -1, 2'd0, 11, 8'd2, 1'b0, 8'd0};

    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_home   = 1'b0;
    cmd_target = '0;
    stop       = 1'b0;
    lim_up     = 1'b0;
    lim_down   = 1'b0;
    tick();
    tick();

    check("rst dir",      32'(dir),       32'd2);
    check("rst position", 32'(position),  32'd0);
    check("rst busy",     32'(busy),      32'd0);
    check("rst done",     32'(done),      32'd0);
    check("rst fault",    32'(fault),     32'd0);
    check("rst ready",    32'(cmd_ready), 32'd1);
    rst = 1'b0;
    tick();
    check("idle ready", 32'(cmd_ready), 32'd1);
    check("idle dir",   32'(dir),       32'd2);

    for (int i = 0; i < 7; i++) begin
      cmd_valid  = 1'b1;
      cmd_home   = vecs[i].home;
      cmd_target = vecs[i].target;
      tick();
      cmd_valid = 1'b0;
      cmd_home  = 1'b0;
      check($sformatf("v%0d dir", i),   32'(dir),   32'(vecs[i].exp_dir));
      check($sformatf("v%0d busy", i),  32'(busy),  32'(vecs[i].exp_dir != 2'd2));
      check($sformatf("v%0d fault clear", i), 32'(fault), 32'd0);
      k = 0;
      while (!done && k < 100) begin
        if (k == vecs[i].lim_at) begin
          check($sformatf("v%0d held pos", i), 32'(position), 32'(vecs[i].held_pos));
          lim_down = 1'b1;
        end
        tick();
        k++;
      end
      check($sformatf("v%0d latency", i), 32'(k),        32'(vecs[i].exp_lat));
      check($sformatf("v%0d position", i), 32'(position), 32'(vecs[i].exp_pos));
      check($sformatf("v%0d fault", i),    32'(fault),    32'(vecs[i].exp_fault));
      lim_down = 1'b0;
      tick();
      check($sformatf("v%0d done pulse", i), 32'(done),      32'd0);
      check($sformatf("v%0d ready", i),      32'(cmd_ready), 32'd1);
      check($sformatf("v%0d idle busy", i),  32'(busy),      32'd0);
      check($sformatf("v%0d fault hold", i), 32'(fault),     32'(vecs[i].exp_fault));
    end

    // lim_up on the same edge as a terminal count: no increment, fault, stop
    cmd_valid  = 1'b1;
    cmd_target = 8'd200;
    tick();
    cmd_valid = 1'b0;
    repeat (7) tick();
    lim_up = 1'b1;
    tick();
    lim_up = 1'b0;
    check("limup position", 32'(position), 32'd3);
    check("limup fault",    32'(fault),    32'd1);
    check("limup dir",      32'(dir),      32'd2);
    check("limup busy",     32'(busy),     32'd1);
    wait_done(10, "limup done");
    check("limup final fault", 32'(fault), 32'd1);
    tick();

    // stop in DOWN: settles without fault, keeps last completed step
    cmd_valid  = 1'b1;
    cmd_target = 8'd0;
    tick();
    cmd_valid = 1'b0;
    check("stop fault clear", 32'(fault), 32'd0);
    check("stop dir down",    32'(dir),   32'd1);
    repeat (5) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop dir",      32'(dir),      32'd2);
    check("stop position", 32'(position), 32'd2);
    check("stop fault",    32'(fault),    32'd0);
    wait_done(10, "stop done");
    check("stop final position", 32'(position), 32'd2);
    tick();

    // stop while idle blocks the handshake
    stop = 1'b1;
    tick();
    check("idle stop ready", 32'(cmd_ready), 32'd0);
    stop = 1'b0;
    tick();
    check("idle ready back", 32'(cmd_ready), 32'd1);

    // asynchronous reset in the middle of a move
    cmd_valid  = 1'b1;
    cmd_target = 8'd10;
    tick();
    cmd_valid = 1'b0;
    repeat (8) tick();
    check("pre-rst position", 32'(position), 32'd4);
    check("pre-rst dir",      32'(dir),      32'd0);
    tick();
    rst = 1'b1;
    #1;
    check("async rst dir",      32'(dir),       32'd2);
    check("async rst position", 32'(position),  32'd0);
    check("async rst busy",     32'(busy),      32'd0);
    check("async rst ready",    32'(cmd_ready), 32'd1);
    #1;
    rst = 1'b0;
    tick();

    // cmd_valid held through a busy period is taken only after done
    cmd_valid  = 1'b1;
    cmd_target = 8'd2;
    tick();
    cmd_target = 8'd1;
    wait_done(20, "held first done");
    check("held first position", 32'(position), 32'd2);
    check("held first busy",     32'(busy),     32'd0);
    tick();
    cmd_valid = 1'b0;
    check("held second busy", 32'(busy), 32'd1);
    check("held second dir",  32'(dir),  32'd1);
    wait_done(20, "held second done");
    check("held second position", 32'(position), 32'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stepper_position_ctrl.md
Name: stepper_position_ctrl

Overview:
- Position controller sitting directly upstream of the stepper phase driver.
- Accepts absolute target-position or homing commands from the Pi-side command path over a valid/ready handshake.
- Drives the driver's direction command (0 up, 1 down, 2 stop) and tracks position by counting step periods.
- Enforces limit switches, a soft stop, and a settle interval before the next command.

Parameters:
- STEP_TIME, 250000: clk cycles per counted step; matches the driver's phase period.
- SETTLE_TIME, 50000: clk cycles dir is held at stop after any motion, before returning to IDLE.
- POS_W, 16: width of position and target.
- HOME_MAX, 4096: maximum steps allowed in homing before a fault is raised.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_home  in  1  with cmd_valid: homing command; cmd_target is ignored
- cmd_target  in  POS_W  absolute target position, unsigned
- stop  in  1  soft abort; level-sensitive
- lim_up  in  1  upper limit switch, active-high, already synchronised
- lim_down  in  1  lower limit switch, active-high, already synchronised
- dir  out  2  to driver: 0 up, 1 down, 2 stop; 3 is never driven
- position  out  POS_W  current position in steps
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a command completes
- fault  out  1  sticky fault flag

Behaviour:
- Reset is asynchronous and active-high. On reset: state=IDLE, dir=2, position=0, step counter=0, busy=0, done=0, fault=0, cmd_ready=1.
- All outputs are registered.
- States: IDLE, UP, DOWN, HOME, SETTLE.
- IDLE:
  - cmd_ready=1, dir=2.
  - A command is accepted on the edge where cmd_valid and cmd_ready are both high. fault clears on that edge.
  - cmd_home=1 -> HOME.
  - cmd_target>position -> UP.
  - cmd_target<position -> DOWN.
  - cmd_target==position -> stay in IDLE; done pulses on the next cycle; dir is unchanged.
  - cmd_target is latched on accept. cmd_ready drops on the cycle after accept.
  - dir takes its new value on the cycle after accept (1-cycle latency).
- UP (dir=0):
  - Step counter runs 0..STEP_TIME-1.
  - At terminal count: position increments by 1 and the counter wraps to 0.
  - If the incremented value equals the target -> SETTLE.
- DOWN (dir=1): mirror of UP; position decrements by 1.
- HOME (dir=1):
  - position is not updated during homing.
  - Steps are counted. lim_down high -> position<=0, then SETTLE.
  - If the step count reaches HOME_MAX without lim_down -> fault=1, then SETTLE; position is unchanged.
- Limits:
  - In UP, lim_up high -> SETTLE immediately and fault=1.
  - In DOWN, lim_down high -> SETTLE immediately and fault=1.
  - lim_up during HOME -> fault=1, then SETTLE.
  - lim_up and lim_down both high in any moving state -> fault=1, then SETTLE.
  - Limits are ignored in IDLE and SETTLE.
  - A limit on the same cycle as a terminal count: limit wins; position is not updated.
- stop:
  - stop high in UP/DOWN/HOME -> SETTLE next edge; fault is not set; position keeps the last completed step.
  - Priority: limit fault over stop over terminal count.
  - stop high in IDLE forces cmd_ready=0.
- SETTLE:
  - dir=2. Counter runs 0..SETTLE_TIME-1, then IDLE with done=1 for exactly one cycle, cmd_ready=1.
  - done also pulses on fault and on stop exits.
- Widths and wrap:
  - position is never driven below 0 or above 2^POS_W-1; targets make that unreachable.
  - In HOME, position is held.
- A command presented while busy is not accepted (cmd_ready=0); cmd_valid may stay high.
- Reset mid-motion returns to the reset state in the same cycle; dir=2 immediately.

Test Plan (STEP_TIME=4, SETTLE_TIME=3, POS_W=8, HOME_MAX=10):
- Reset, then move to target 3 from 0:
  - dir=0 one cycle after accept.
  - position reaches 3 after 12 cycles in UP.
  - dir=2 for 3 cycles, then done pulses once and cmd_ready=1.
- From position 3, command target 1 -> dir=1, position 3->2->1 at 4-cycle intervals, then SETTLE and done. Command target 1 again -> done next cycle; dir stays 2; busy stays 0.
- Homing from position 5 with lim_down asserted after 7 cycles -> dir=1, position held at 5 until lim_down, then position=0, SETTLE, done, fault=0.
- Homing with lim_down never asserted -> after 10 steps (40 cycles) fault=1, SETTLE, done. fault stays 1 until the next accepted command clears it.
- UP toward 200:
  - lim_up on the same cycle as a terminal count -> position not incremented, fault=1, dir=2 next cycle.
  - Separately, stop in DOWN -> SETTLE, fault=0.
- rst asserted mid-UP at position 4 -> dir=2, position=0, busy=0 with no clock edge. cmd_valid held high during busy is accepted only after done.
